// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: shifts a latched parallel pattern out MSB-first
// on x, one bit per clock, with x_valid qualifier and busy/done handshake.
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LW    = 5,
  parameter int RW    = 4,
  parameter int GAP   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
  input  logic [RW-1:0]    passes,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GLAST =
    GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [IW-1:0]    top;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    nidx;
  logic [RW-1:0]    pcnt;
  logic [GW-1:0]    gcnt;
  logic [IW-1:0]    len_top;
  logic [RW-1:0]    pass_eff;

  // clamp requested length/passes; only ever feeds registers
  always_comb begin
    len_top  = IW'(length - LW'(1));
    pass_eff = passes;
    if (length == '0 || int'(length) > WIDTH)
      len_top = IW'(WIDTH - 1);
    if (passes == '0)
      pass_eff = RW'(1);
    nidx = idx - IW'(1);
  end

  // transfer FSM with registered serial outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      pat     <= '0;
      top     <= '0;
      idx     <= '0;
      pcnt    <= '0;
      gcnt    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start && !abort) begin
            pat     <= pattern;
            top     <= len_top;
            idx     <= len_top;
            pcnt    <= pass_eff;
            gcnt    <= '0;
            x       <= pattern[len_top];
            x_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state   <= S_IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (idx != '0) begin
            idx <= nidx;
            x   <= pat[nidx];
          end else if (pcnt > RW'(1)) begin
            pcnt <= pcnt - RW'(1);
            if (GAP > 0) begin
              state   <= S_GAP;
              gcnt    <= '0;
              x       <= 1'b0;
              x_valid <= 1'b0;
            end else begin
              idx <= top;
              x   <= pat[top];
            end
          end else begin
            state   <= S_DONE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            state   <= S_IDLE;
            gcnt    <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (gcnt == GLAST) begin
            state   <= S_SHIFT;
            gcnt    <= '0;
            idx     <= top;
            x       <= pat[top];
            x_valid <= 1'b1;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: scoreboard bench for serial_pattern_gen,
// GAP=0 instance (u0) and GAP=2 instance (u2).
module tb_serial_pattern_gen;

  logic        clock;
  logic        reset;
  logic        start0;
  logic        start2;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [3:0]  passes;
  logic        abort;
  logic        x0, xv0, b0, d0;
  logic        x2, xv2, b2, d2;

  int checks = 0;
  int errors = 0;

  logic [3:0] q0[$];
  logic [3:0] q2[$];
  string      t0[$];
  string      t2[$];

  localparam logic [3:0] IDLE = 4'b0000;
  localparam logic [3:0] DONE = 4'b0001;

  serial_pattern_gen #(.WIDTH(16), .LW(5), .RW(4), .GAP(0)) u0 (
    .clock(clock), .reset(reset), .start(start0),
    .pattern(pattern), .length(length), .passes(passes),
    .abort(abort), .x(x0), .x_valid(xv0), .busy(b0), .done(d0)
  );

  serial_pattern_gen #(.WIDTH(16), .LW(5), .RW(4), .GAP(2)) u2 (
    .clock(clock), .reset(reset), .start(start2),
    .pattern(pattern), .length(length), .passes(passes),
    .abort(abort), .x(x2), .x_valid(xv2), .busy(b2), .done(d2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // pop expected {x,x_valid,busy,done} and compare away from the edge
  always @(negedge clock) begin
    logic [3:0] e;
    logic [3:0] o;
    string      t;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      t = t0.pop_front();
      o = {x0, xv0, b0, d0};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s u0 obs=%b exp=%b", t, o, e);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      t = t2.pop_front();
      o = {x2, xv2, b2, d2};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s u2 obs=%b exp=%b", t, o, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input bit sel, input logic [3:0] e,
                      input string tag);
    if (sel) begin
      q2.push_back(e);
      t2.push_back(tag);
    end else begin
      q0.push_back(e);
      t0.push_back(tag);
    end
  endtask

  // reference stream: passes of L bits, gap cycles between, done, idle
  task automatic push_model(input bit sel, input string tag,
                            input logic [15:0] p, input int len,
                            input int ps, input int gap,
                            output int n);
    int l;
    int pc;
    l  = (len == 0 || len > 16) ? 16 : len;
    pc = (ps == 0) ? 1 : ps;
    n  = 0;
    for (int k = 0; k < pc; k++) begin
      if (k > 0)
        for (int g = 0; g < gap; g++) begin
          push(sel, 4'b0010, tag);
          n++;
        end
      for (int i = l - 1; i >= 0; i--) begin
        push(sel, {p[i], 3'b110}, tag);
        n++;
      end
    end
    push(sel, DONE, tag);
    push(sel, IDLE, tag);
    n += 2;
  endtask

  task automatic xfer(input bit sel, input string tag,
                      input logic [15:0] p, input int len,
                      input int ps, input int gap);
    int n;
    pattern = p;
    length  = 5'(len);
    passes  = 4'(ps);
    if (sel) start2 = 1'b1;
    else     start0 = 1'b1;
    tick();
    start0  = 1'b0;
    start2  = 1'b0;
    pattern = ~p;
    length  = 5'd1;
    passes  = 4'd7;
    push_model(sel, tag, p, len, ps, gap, n);
    run(n);
  endtask

  initial begin
    logic [14:0] s;
    int          n;
    s       = 15'b111001110011001;
    reset   = 1'b1;
    start0  = 1'b0;
    start2  = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    length  = '0;
    passes  = '0;

    tick();
    tick();
    push(0, IDLE, "rst0");
    push(1, IDLE, "rst0");
    run(1);
    reset = 1'b0;

    pattern = 16'h7399;
    length  = 5'd15;
    passes  = 4'd1;
    start0  = 1'b1;
    tick();
    start0  = 1'b0;
    for (int i = 14; i >= 0; i--)
      push(0, {s[i], 3'b110}, "p7399");
    push(0, DONE, "p7399_done");
    push(0, IDLE, "p7399_idle");
    run(17);

    xfer(0, "a5a5_len0", 16'hA5A5, 0, 0, 0);
    xfer(0, "a5a5_len31", 16'hA5A5, 31, 0, 0);
    xfer(1, "mp_gap2", 16'h0005, 3, 3, 2);
    xfer(0, "b2b_gap0", 16'h0002, 2, 2, 0);
    xfer(0, "p0_len5", 16'h0016, 5, 0, 0);

    pattern = 16'h7399;
    length  = 5'd15;
    passes  = 4'd1;
    start0  = 1'b1;
    tick();
    start0  = 1'b0;
    for (int i = 14; i >= 10; i--)
      push(0, {s[i], 3'b110}, "abrt_bits");
    run(2);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    push(0, IDLE, "abrt_idle");
    xfer(0, "abrt_restart", 16'h0400, 11, 1, 0);

    abort   = 1'b1;
    start0  = 1'b1;
    pattern = 16'hFFFF;
    length  = 5'd4;
    passes  = 4'd1;
    tick();
    abort  = 1'b0;
    start0 = 1'b0;
    push(0, IDLE, "abrt_blocks");
    push(0, IDLE, "abrt_blocks2");
    run(2);

    pattern = 16'h0001;
    length  = 5'd2;
    passes  = 4'd1;
    start0  = 1'b1;
    tick();
    start0  = 1'b0;
    push(0, 4'b0110, "done_ign_b1");
    push(0, 4'b1110, "done_ign_b0");
    push(0, DONE, "done_ign_done");
    push(0, IDLE, "done_ign_idle");
    push(0, IDLE, "done_ign_idle2");
    run(2);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    run(2);

    pattern = 16'h0005;
    length  = 5'd3;
    passes  = 4'd3;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    push(1, 4'b1110, "gap_abrt");
    push(1, 4'b0110, "gap_abrt");
    push(1, 4'b1110, "gap_abrt");
    push(1, 4'b0010, "gap_abrt_gap");
    run(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    push(1, IDLE, "gap_abrt_idle");
    push(1, IDLE, "gap_abrt_idle2");
    run(2);

    pattern = 16'hA5A5;
    length  = 5'd16;
    passes  = 4'd1;
    start0  = 1'b1;
    tick();
    start0  = 1'b0;
    for (int i = 15; i >= 12; i--)
      push(0, {pattern[i], 3'b110}, "rst_mid");
    run(3);
    reset  = 1'b1;
    start0 = 1'b1;
    tick();
    push(0, IDLE, "rst_mid_idle");
    tick();
    push(0, IDLE, "rst_mid_idle2");
    reset  = 1'b0;
    start0 = 1'b0;
    tick();
    push(0, IDLE, "rst_mid_noacc");
    run(1);

    n = q0.size() + q2.size();
    checks++;
    assert (n == 0) else begin
      errors++;
      $error("FAIL drain obs=%0d exp=0", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
